// File: rtl/pc_ras_if.sv
// pc_ras_if: control/data bundle between the datapath sequencer and the PC unit.
interface pc_ras_if #(parameter int WIDTH = 16);
    logic             ld_pc;
    logic [2:0]       sel_pc;
    logic [WIDTH-1:0] bus;
    logic [WIDTH-1:0] eab_out;
    logic             clr_err;
    logic [WIDTH-1:0] pc;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_err;
    modport master (output ld_pc, sel_pc, bus, eab_out, clr_err, input pc, ras_empty, ras_full, ras_err);
    modport slave (input ld_pc, sel_pc, bus, eab_out, clr_err, output pc, ras_empty, ras_full, ras_err);
endinterface

// File: rtl/pc_ras.sv
// pc_ras: program counter with a one-cycle call/return stack.
// Define PC_RAS_EN to build the return-address stack; otherwise CALL/RET act as plain jumps.
module pc_ras #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter logic [WIDTH-1:0] RESET_VEC = 16'h3000
) (
    input logic     clk,
    input logic     reset,
    pc_ras_if.slave b
);
    logic [WIDTH-1:0] pc_q, pc_d, pc_inc, ret_pc;
    assign pc_inc = pc_q + WIDTH'(1);
`ifdef PC_RAS_EN
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] tp_q, tp_d, wr_idx;
    logic [AW:0] cnt_q, cnt_d;
    logic err_q, err_d, call, ret, empty, full, pop;
    assign call = b.ld_pc && b.sel_pc == 3'b011;
    assign ret = b.ld_pc && b.sel_pc == 3'b100;
    assign empty = cnt_q == '0;
    assign full = cnt_q == FULL;
    assign pop = ret && !empty;
    assign wr_idx = tp_q + AW'(1);
    // underflowing RET falls back to the bus target
    assign ret_pc = empty ? b.bus : mem_q[tp_q];
    always_comb begin
        tp_d = call ? wr_idx : pop ? tp_q - AW'(1) : tp_q;
        cnt_d = (call && !full) ? cnt_q + (AW+1)'(1) : pop ? cnt_q - (AW+1)'(1) : cnt_q;
        err_d = ((call && full) || (ret && empty)) ? 1'b1 : b.clr_err ? 1'b0 : err_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tp_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            tp_q <= tp_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    // storage is not reset; a full stack overwrites its oldest slot by wrapping
    always_ff @(posedge clk)
        if (call) mem_q[wr_idx] <= pc_inc;
    assign b.ras_empty = empty;
    assign b.ras_full = full;
    assign b.ras_err = err_q;
`else
    assign ret_pc = b.bus;
    assign b.ras_empty = 1'b1;
    assign b.ras_full = 1'b0;
    assign b.ras_err = 1'b0;
`endif
    assign pc_d = !b.ld_pc ? pc_q :
                  b.sel_pc == 3'b000 ? pc_inc :
                  (b.sel_pc == 3'b001 || b.sel_pc == 3'b011) ? b.eab_out :
                  b.sel_pc == 3'b010 ? b.bus :
                  b.sel_pc == 3'b100 ? ret_pc : pc_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc_q <= RESET_VEC;
        else pc_q <= pc_d;
    end
    assign b.pc = pc_q;
endmodule

// File: tb/tb_pc_ras.sv
// tb_pc_ras: random and directed stimulus checked against a queue-based stack model.
module tb_pc_ras;
`ifdef PC_RAS_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif
    localparam int DEPTH = 8;
    logic clk = 1'b0;
    logic reset = 1'b1;
    bit go = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] m_pc;
    logic [15:0] m_inc;
    logic [15:0] stk[$];
    logic m_err;

    pc_ras_if #(.WIDTH(16)) bi();
    pc_ras #(.WIDTH(16), .DEPTH(DEPTH), .RESET_VEC(16'h3000)) dut (.clk(clk), .reset(reset), .b(bi));

    always #5 clk = ~clk;

    // reference: PC plus a bounded LIFO queue that drops its oldest entry on overflow
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pc = 16'h3000;
            stk = {};
            m_err = 1'b0;
        end else begin
            m_inc = m_pc + 16'd1;
            if (EN && bi.clr_err) m_err = 1'b0;
            if (bi.ld_pc) begin
                case (bi.sel_pc)
                    3'd0: m_pc = m_inc;
                    3'd1: m_pc = bi.eab_out;
                    3'd2: m_pc = bi.bus;
                    3'd3: begin
                        m_pc = bi.eab_out;
                        if (EN) begin
                            if (stk.size() == DEPTH) begin
                                void'(stk.pop_front());
                                m_err = 1'b1;
                            end
                            stk.push_back(m_inc);
                        end
                    end
                    3'd4: begin
                        if (EN && stk.size() > 0) m_pc = stk.pop_back();
                        else begin
                            m_pc = bi.bus;
                            if (EN) m_err = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (go) begin
            chk("pc", bi.pc, m_pc);
            chk("ras_empty", 16'(bi.ras_empty), 16'(EN ? stk.size() == 0 : 1'b1));
            chk("ras_full", 16'(bi.ras_full), 16'(EN ? stk.size() == DEPTH : 1'b0));
            chk("ras_err", 16'(bi.ras_err), 16'(m_err));
        end
    end

    task automatic drive(input logic ld, input logic [2:0] sel, input logic [15:0] eab,
                         input logic [15:0] bs, input logic clr);
        bi.ld_pc = ld;
        bi.sel_pc = sel;
        bi.eab_out = eab;
        bi.bus = bs;
        bi.clr_err = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #1 reset = 1'b0;
        #1;
        chk("rst_pc", bi.pc, 16'h3000);
        chk("rst_empty", 16'(bi.ras_empty), 16'd1);
        chk("rst_full", 16'(bi.ras_full), 16'd0);
        chk("rst_err", 16'(bi.ras_err), 16'd0);
        #1 reset = 1'b1;
    endtask

    initial begin
        bi.ld_pc = 1'b0;
        bi.sel_pc = 3'd0;
        bi.eab_out = '0;
        bi.bus = '0;
        bi.clr_err = 1'b0;
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        chk("init_pc", bi.pc, 16'h3000);
        chk("init_empty", 16'(bi.ras_empty), 16'd1);
        chk("init_full", 16'(bi.ras_full), 16'd0);
        chk("init_err", 16'(bi.ras_err), 16'd0);
        reset = 1'b1;
        go = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 3'd0, 16'h0, 16'h0, 1'b0);
            chk("inc", bi.pc, 16'h3000 + 16'(i));
        end
        drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0);
        chk("hold", bi.pc, 16'h3003);
        drive(1'b1, 3'd0, 16'h0, 16'h0, 1'b0);
        drive(1'b1, 3'd0, 16'h0, 16'h0, 1'b0);
        chk("pre_call", bi.pc, 16'h3005);
        drive(1'b1, 3'd3, 16'h4000, 16'h0, 1'b0);
        chk("call_pc", bi.pc, 16'h4000);
        chk("call_empty", 16'(bi.ras_empty), 16'(!EN));
        drive(1'b1, 3'd4, 16'h0, 16'h7777, 1'b0);
        chk("ret_pc", bi.pc, EN ? 16'h3006 : 16'h7777);
        chk("ret_empty", 16'(bi.ras_empty), 16'd1);
        drive(1'b1, 3'd1, 16'hFFFF, 16'h0, 1'b0);
        drive(1'b1, 3'd0, 16'h0, 16'h0, 1'b0);
        chk("wrap_pc", bi.pc, 16'h0000);
        chk("wrap_err", 16'(bi.ras_err), 16'd0);
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 3'd3, 16'h4100 + 16'(16 * i), 16'h0, 1'b0);
            if (i == 7) chk("full8", 16'(bi.ras_full), 16'(EN));
            if (i == 7) chk("err8", 16'(bi.ras_err), 16'd0);
        end
        chk("ovf_full", 16'(bi.ras_full), 16'(EN));
        chk("ovf_err", 16'(bi.ras_err), 16'(EN));
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'd4, 16'h0, 16'hB000 + 16'(i), 1'b0);
            chk("lifo", bi.pc, EN ? 16'h4101 + 16'(16 * (7 - i)) : 16'hB000 + 16'(i));
        end
        chk("lifo_empty", 16'(bi.ras_empty), 16'd1);
        drive(1'b1, 3'd5, 16'h0, 16'h0, 1'b1);
        chk("clr_err", 16'(bi.ras_err), 16'd0);
        chk("sel5_hold", bi.pc, EN ? 16'h4101 : 16'hB007);
        drive(1'b1, 3'd4, 16'h0, 16'h5123, 1'b0);
        chk("unf_pc", bi.pc, 16'h5123);
        chk("unf_err", 16'(bi.ras_err), 16'(EN));
        drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b1);
        chk("clr_noload", 16'(bi.ras_err), 16'd0);
        drive(1'b1, 3'd4, 16'h0, 16'h5123, 1'b1);
        chk("set_wins", 16'(bi.ras_err), 16'(EN));
        drive(1'b1, 3'd3, 16'h6000, 16'h0, 1'b0);
        drive(1'b1, 3'd3, 16'h6100, 16'h0, 1'b0);
        chk("two_calls", bi.pc, 16'h6100);
        pulse_reset();
        drive(1'b1, 3'd4, 16'h0, 16'h1234, 1'b0);
        chk("post_rst_ret", bi.pc, 16'h1234);
        chk("post_rst_err", 16'(bi.ras_err), 16'(EN));
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) pulse_reset();
            drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 16'($urandom),
                  16'($urandom), $urandom_range(0, 9) == 0);
        end
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pc_ras.md
# pc_ras

Parametrised program-counter unit for the datapath: it holds the fetch address and selects the next one from increment, EAB, bus, call or return. It adds a hardware return-address stack (RAS) so subroutine call and return happen in one cycle each. It sits between the EAB adder and the bus driver, and feeds the MAR/fetch path.

## Interface
- `WIDTH`, 16: PC and address width in bits.
- `DEPTH`, 8: number of RAS entries; power of two, ≥2.
- `RESET_VEC`, 16'h3000: PC value after reset.

- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `ld_pc` in 1: update enable; when low the PC and RAS hold.
- `sel_pc` in 3: next-PC source. 000 = PC+1, 001 = eab_out, 010 = bus, 011 = CALL, 100 = RET, 101–111 = hold.
- `bus` in WIDTH: bus value for a JMP-style load.
- `eab_out` in WIDTH: effective-address adder result, used as the branch/call target.
- `clr_err` in 1: synchronous clear of `ras_err`.
- `pc` out WIDTH: current PC, registered.
- `ras_empty` out 1: RAS holds 0 entries.
- `ras_full` out 1: RAS holds DEPTH entries.
- `ras_err` out 1: sticky overflow/underflow flag.

## Operation
- State:
  - PC register.
  - RAS storage array of DEPTH×WIDTH.
  - Top pointer `tp` of log2(DEPTH) bits, circular.
  - Count `cnt` of log2(DEPTH)+1 bits, saturating 0..DEPTH.
  - `ras_err` flag.
- All updates below happen only on a rising `clk` with `ld_pc`=1. With `ld_pc`=0 every register holds; `clr_err` still acts.
- PC+1 is computed modulo 2^WIDTH, so 16'hFFFF+1 = 16'h0000 with no flag.
- 000: PC ← PC+1.
- 001: PC ← eab_out.
- 010: PC ← bus.
- 011 CALL:
  - PC ← eab_out.
  - Push PC+1: write it at `tp`+1, then `tp` ← `tp`+1.
  - If `cnt`<DEPTH, `cnt` increments.
  - If `cnt`=DEPTH (full), the oldest entry is overwritten (circular), `cnt` stays DEPTH and `ras_err` ← 1.
- 100 RET:
  - If `cnt`>0: PC ← entry[`tp`], then `tp` ← `tp`−1 and `cnt` ← `cnt`−1.
  - If `cnt`=0 (underflow): PC ← bus (fallback), pointer and count are unchanged, and `ras_err` ← 1.
- 101–111: PC and RAS hold; no error.
- `ras_err` is sticky:
  - Set by overflow or underflow.
  - Cleared by `clr_err`=1.
  - If set and clear occur in the same cycle, the set wins.
- `ras_empty` = (`cnt`==0) and `ras_full` = (`cnt`==DEPTH). Both are combinational from `cnt`.
- RAS storage contents are not reset; only the pointer and count are.

## Timing
- Reset (`reset`=0, asynchronous, immediate):
  - `pc`=RESET_VEC.
  - `tp`=0 and `cnt`=0, so `ras_empty`=1 and `ras_full`=0.
  - `ras_err`=0.
- Reset asserted mid-operation discards all stack contents logically (`cnt`=0). Release is synchronous to `clk` via the codebase's standard reset handling.
- Latency: the new `pc` is visible one cycle after the `ld_pc` edge. There is no combinational path from inputs to `pc`.
- A CALL in cycle N followed by a RET in cycle N+1 returns the PC+1 captured at cycle N. The stack write and read never conflict, because the write completes at the edge.
- The RET data path reads the registered `tp` entry. There is no bypass requirement beyond the one-cycle ordering above.

## Configuration
- `PC_RAS_EN` defined:
  - The RAS, `tp`, `cnt` and `ras_err` are built as described.
- `PC_RAS_EN` undefined:
  - No storage is built.
  - CALL behaves as 001 (PC ← eab_out).
  - RET behaves as 010 (PC ← bus).
  - `ras_empty`=1, `ras_full`=0 and `ras_err`=0 constantly.
  - `clr_err` is ignored.

## Test plan
- Reset then 3 cycles with `sel_pc`=000 and `ld_pc`=1 → `pc` = 3000, 3001, 3002, 3003. Drop `ld_pc` → `pc` holds at 3003.
- With `pc`=FFFF and `sel_pc`=000 → `pc`=0000 and `ras_err`=0.
- CALL at `pc`=3005 with `eab_out`=4000 → `pc`=4000 and `cnt`=1. RET next cycle → `pc`=3006 and `ras_empty`=1.
- DEPTH=8: 9 nested CALLs → `ras_full`=1 and `ras_err`=1. Then 8 RETs return the 2nd..9th pushed addresses in LIFO order, and `ras_empty`=1.
- RET on an empty stack with `bus`=5123 → `pc`=5123 and `ras_err`=1. Assert `clr_err` → `ras_err`=0. Assert `clr_err` during an underflow → `ras_err` stays 1.
- Assert `reset` asynchronously between edges after 2 CALLs → `pc`=3000, `ras_empty`=1 and `ras_err`=0 immediately. A following RET takes the underflow path.
